// File: rtl/stopwatch_ctrl_pkg.sv
// Shared definitions for the stopwatch control FSM: state encodings and default timing.
package stopwatch_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10,
      ST_LAP   = 2'b11
   } sw_state_t;

   localparam int HOLD_CYCLES_DEF = 750;
   localparam int HOLD_W_DEF      = 10;

endpackage

// File: rtl/stopwatch_ctrl_edge_rise.sv
// Rising-edge detector on a debounced button level; history flop reset value is selectable
// so a button held through reset does not look like a fresh press.
module edge_rise #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic rise
);

   logic prev;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) prev <= RST_VAL;
      else        prev <= btn;
   end

   assign rise = btn & ~prev;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: start/stop and lap/reset sequencing, long-press master clear,
// registered run / clear / hold_display outputs for the time counter and display.
//
//   state    | meaning
//   ---------+------------------------------------------------
//   ST_IDLE  | stopped and cleared, waiting for start
//   ST_RUN   | counting, display live
//   ST_PAUSE | counting stopped, value retained
//   ST_LAP   | counting continues, display frozen on lap value
module stopwatch_ctrl
   import stopwatch_ctrl_pkg::*;
#(
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF,
   parameter int HOLD_W      = HOLD_W_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_start,
   input  logic       btn_lap,
   output logic       run,
   output logic       clear,
   output logic       hold_display,
   output logic [1:0] state_o
);

   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(HOLD_CYCLES);

   sw_state_t         state, state_nxt;
   logic              clear_nxt, run_nxt, hold_nxt;
   logic              rise_start, rise_lap, long_fire;
   logic [HOLD_W-1:0] hold_cnt;

   edge_rise #(.RST_VAL(1'b1)) u_rise_start (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_start),
      .rise (rise_start)
   );

   edge_rise #(.RST_VAL(1'b1)) u_rise_lap (
      .clk  (clk),
      .rst_n(rst_n),
      .btn  (btn_lap),
      .rise (rise_lap)
   );

   // Saturates one past the fire value so each press gives a single master clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                  hold_cnt <= '0;
      else if (!btn_lap)           hold_cnt <= '0;
      else if (hold_cnt != HOLD_SAT) hold_cnt <= hold_cnt + 1'b1;
   end

   assign long_fire = btn_lap & (hold_cnt == HOLD_LAST);

   // Priority: long press, then start, then lap (a lap rise colliding with start is dropped).
   always_comb begin
      state_nxt = state;
      clear_nxt = 1'b0;
      if (long_fire) begin
         state_nxt = ST_IDLE;
         clear_nxt = 1'b1;
      end else if (rise_start) begin
         case (state)
            ST_IDLE:  state_nxt = ST_RUN;
            ST_RUN:   state_nxt = ST_PAUSE;
            ST_LAP:   state_nxt = ST_PAUSE;
            ST_PAUSE: state_nxt = ST_RUN;
            default:  state_nxt = ST_IDLE;
         endcase
      end else if (rise_lap) begin
         case (state)
            ST_IDLE:  clear_nxt = 1'b1;
            ST_RUN:   state_nxt = ST_LAP;
            ST_LAP:   state_nxt = ST_RUN;
            ST_PAUSE: begin
               state_nxt = ST_IDLE;
               clear_nxt = 1'b1;
            end
            default:  state_nxt = ST_IDLE;
         endcase
      end
      clear_nxt = clear_nxt & ~clear;
      run_nxt   = (state_nxt == ST_RUN) || (state_nxt == ST_LAP);
      hold_nxt  = (state_nxt == ST_LAP);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         run          <= 1'b0;
         clear        <= 1'b0;
         hold_display <= 1'b0;
      end else begin
         state        <= state_nxt;
         run          <= run_nxt;
         clear        <= clear_nxt;
         hold_display <= hold_nxt;
      end
   end

   assign state_o = state;

endmodule
